pipe_ctrl: RTL



---
 rtl/pipe_ctrl_pkg.sv | 14 +
 rtl/pipe_ctrl_hazard_detect.sv | 27 ++
 rtl/pipe_ctrl.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline control unit.
// Control-word encodings and the opcodes it decodes.
package pipe_ctrl_pkg;

    localparam int CTRL_W = 2;

    localparam logic [1:0] CTRL_STATE_Default = 2'b00;
    localparam logic [1:0] CTRL_STATE_Stalled = 2'b01;
    localparam logic [1:0] CTRL_STATE_Bubble  = 2'b10;

    localparam logic [6:0] Opcode_Load  = 7'b0000011;
    localparam logic [6:0] Opcode_Fence = 7'b0001111;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use comparator: a load in EX feeds a source of the
// instruction in ID, so ID must wait one cycle.
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] id_rs1_addr_i,
    input  logic [4:0] id_rs2_addr_i,
    input  logic       id_rs1_read_i,
    input  logic       id_rs2_read_i,
    input  logic [6:0] ex_opcode_i,
    input  logic [4:0] ex_rd_addr_i,
    input  logic       ex_wreg_i,
    output logic       load_use_o
);

    logic ex_load;
    logic rs1_hit;
    logic rs2_hit;

    assign ex_load = (ex_opcode_i == Opcode_Load) && ex_wreg_i
                     && (ex_rd_addr_i != 5'd0);
    assign rs1_hit = id_rs1_read_i && (id_rs1_addr_i == ex_rd_addr_i);
    assign rs2_hit = id_rs2_read_i && (id_rs2_addr_i == ex_rd_addr_i);

    assign load_use_o = ex_load && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control unit: per-stage hold/squash/advance words.
// Optional perf counters under PIPE_CTRL_PERF_EN.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int DRAIN_CYCLES = 3,
    parameter int MEM_TIMEOUT  = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs1_addr_i,
    input  logic [4:0]  id_rs2_addr_i,
    input  logic        id_rs1_read_i,
    input  logic        id_rs2_read_i,
    input  logic [6:0]  id_opcode_i,
    input  logic [6:0]  ex_opcode_i,
    input  logic [4:0]  ex_rd_addr_i,
    input  logic        ex_wreg_i,
    input  logic        ex_branch_taken_i,
    input  logic        mem_req_i,
    input  logic        mem_ready_i,
    output logic [1:0]  pc_ctrl_o,
    output logic [1:0]  if_id_ctrl_o,
    output logic [1:0]  id_ex_ctrl_o,
    output logic [1:0]  ex_mem_ctrl_o,
    output logic [1:0]  mem_wb_ctrl_o,
`ifdef PIPE_CTRL_PERF_EN
    output logic [63:0] perf_stall_cnt_o,
    output logic [63:0] perf_flush_cnt_o,
`endif
    output logic        mem_timeout_o
);

    localparam int TW = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic {
        S_RUN,
        S_DRAIN
    } state_e;

    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [TW-1:0] to_q, to_d;
    logic          timeout_q, timeout_d;

    logic mem_wait;
    logic load_use;
    logic drain_act;
    logic flush;

    hazard_detect u_hazard (
        .id_rs1_addr_i (id_rs1_addr_i),
        .id_rs2_addr_i (id_rs2_addr_i),
        .id_rs1_read_i (id_rs1_read_i),
        .id_rs2_read_i (id_rs2_read_i),
        .ex_opcode_i   (ex_opcode_i),
        .ex_rd_addr_i  (ex_rd_addr_i),
        .ex_wreg_i     (ex_wreg_i),
        .load_use_o    (load_use)
    );

    assign mem_wait  = mem_req_i && !mem_ready_i;
    assign drain_act = ((state_q == S_DRAIN) && (cnt_q != 4'd0))
                       || ((state_q == S_RUN) && (id_opcode_i == Opcode_Fence));

    always_comb begin
        pc_ctrl_o     = CTRL_STATE_Default;
        if_id_ctrl_o  = CTRL_STATE_Default;
        id_ex_ctrl_o  = CTRL_STATE_Default;
        ex_mem_ctrl_o = CTRL_STATE_Default;
        mem_wb_ctrl_o = CTRL_STATE_Default;
        state_d       = state_q;
        cnt_d         = cnt_q;
        flush         = 1'b0;

        priority case (1'b1)
            mem_wait: begin
                pc_ctrl_o     = CTRL_STATE_Stalled;
                if_id_ctrl_o  = CTRL_STATE_Stalled;
                id_ex_ctrl_o  = CTRL_STATE_Stalled;
                ex_mem_ctrl_o = CTRL_STATE_Stalled;
                mem_wb_ctrl_o = CTRL_STATE_Bubble;
            end
            ex_branch_taken_i: begin
                if_id_ctrl_o = CTRL_STATE_Bubble;
                id_ex_ctrl_o = CTRL_STATE_Bubble;
                state_d      = S_RUN;
                cnt_d        = 4'd0;
                flush        = 1'b1;
            end
            drain_act: begin
                pc_ctrl_o    = CTRL_STATE_Stalled;
                if_id_ctrl_o = CTRL_STATE_Stalled;
                id_ex_ctrl_o = CTRL_STATE_Bubble;
                // The fence stays in ID while draining, so even a
                // one-bubble drain enters DRAIN (count 0) to let it pass.
                if (state_q == S_RUN) begin
                    state_d = S_DRAIN;
                    cnt_d   = 4'(DRAIN_CYCLES - 1);
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            load_use: begin
                pc_ctrl_o    = CTRL_STATE_Stalled;
                if_id_ctrl_o = CTRL_STATE_Stalled;
                id_ex_ctrl_o = CTRL_STATE_Bubble;
            end
            default: begin
                state_d = S_RUN;
            end
        endcase

        if (rst) begin
            pc_ctrl_o     = CTRL_STATE_Bubble;
            if_id_ctrl_o  = CTRL_STATE_Bubble;
            id_ex_ctrl_o  = CTRL_STATE_Bubble;
            ex_mem_ctrl_o = CTRL_STATE_Bubble;
            mem_wb_ctrl_o = CTRL_STATE_Bubble;
            flush         = 1'b0;
        end
    end

    always_comb begin
        to_d      = '0;
        timeout_d = timeout_q;
        if (mem_wait) begin
            to_d = (to_q == TW'(MEM_TIMEOUT)) ? to_q : to_q + TW'(1);
            if (to_q >= TW'(MEM_TIMEOUT - 1)) begin
                timeout_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_RUN;
            cnt_q     <= 4'd0;
            to_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            to_q      <= to_d;
            timeout_q <= timeout_d;
        end
    end

    assign mem_timeout_o = timeout_q;

`ifdef PIPE_CTRL_PERF_EN
    logic [63:0] stall_q;
    logic [63:0] flush_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (pc_ctrl_o == CTRL_STATE_Stalled) begin
                stall_q <= stall_q + 64'd1;
            end
            if (flush) begin
                flush_q <= flush_q + 64'd1;
            end
        end
    end

    assign perf_stall_cnt_o = stall_q;
    assign perf_flush_cnt_o = flush_q;
`else
    logic unused_flush;
    assign unused_flush = flush;
`endif

endmodule
